// File: rtl/csram_reconfig_loader_pkg.sv
// Shared types and sizing helpers for the CSRAM reconfiguration loader.
package csram_cfg_pkg;

    localparam int DEF_NUM_CORES_NEW = 9;
    localparam int DEF_CSRAM_WIDTH   = 368;
    localparam int DEF_NUM_NEURONS   = 256;
    localparam int DEF_WORD_WIDTH    = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_WRITE    = 3'd2,
        ST_VERIFY   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Number of stream words needed to cover one CSRAM row (last word may be partial).
    function automatic int words_per_row(input int csram_w, input int word_w);
        return (csram_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/csram_reconfig_loader_if.sv
// Bus bundles for the loader: the narrow config word stream and the per-core
// parameter write/readback port.
interface csram_stream_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

interface csram_param_if #(
    parameter int CORE_W      = 4,
    parameter int ADDR_W      = 8,
    parameter int CSRAM_WIDTH = 368
);
    logic [CORE_W-1:0]      param_core;
    logic                   param_wen;
    logic [ADDR_W-1:0]      param_addr;
    logic [CSRAM_WIDTH-1:0] param_data_in;
    logic [CSRAM_WIDTH-1:0] param_data_out;

    modport master (output param_core, output param_wen, output param_addr,
                    output param_data_in, input param_data_out);
    modport slave  (input param_core, input param_wen, input param_addr,
                    input param_data_in, output param_data_out);
endinterface

// File: rtl/csram_reconfig_loader_row_packer.sv
// Packs accepted stream words into a CSRAM row; word 0 lands in the LSBs and
// bits of the final word that fall past the row width are dropped.
module row_packer
    import csram_cfg_pkg::*;
#(
    parameter int CSRAM_WIDTH = DEF_CSRAM_WIDTH,
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   accept_i,
    input  logic [WORD_WIDTH-1:0]  word_i,
    output logic [CSRAM_WIDTH-1:0] row_o,
    output logic                   row_full_o
);
    localparam int WPR = words_per_row(CSRAM_WIDTH, WORD_WIDTH);
    localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(WPR - 1);

    logic [WCW-1:0]         w_q, w_d;
    logic [CSRAM_WIDTH-1:0] row_q, row_d;
    logic [CSRAM_WIDTH-1:0] slot_mask;
    logic [CSRAM_WIDTH-1:0] slot_data;

    assign row_o      = row_q;
    assign row_full_o = accept_i && (w_q == W_LAST);

    // Merge the incoming word into its slot and step the word counter.
    always_comb begin
        w_d       = w_q;
        row_d     = row_q;
        slot_mask = CSRAM_WIDTH'({WORD_WIDTH{1'b1}}) << (int'(w_q) * WORD_WIDTH);
        slot_data = CSRAM_WIDTH'(word_i) << (int'(w_q) * WORD_WIDTH);
        if (clr_i) begin
            w_d = '0;
        end else if (accept_i) begin
            row_d = (row_q & ~slot_mask) | slot_data;
            w_d   = (w_q == W_LAST) ? '0 : w_q + WCW'(1);
        end
    end

    // Word counter and row buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            row_q <= '0;
        end else begin
            w_q   <= w_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/csram_reconfig_loader.sv
// CSRAM reconfiguration loader: packs the config word stream into rows and
// writes them core 0 row 0 onward. Defining CSRAM_RECONFIG_VERIFY_EN adds a
// readback VERIFY cycle after each write with a sticky mismatch flag.
module csram_reconfig_loader
    import csram_cfg_pkg::*;
#(
    parameter int NUM_CORES_NEW = DEF_NUM_CORES_NEW,
    parameter int CSRAM_WIDTH   = DEF_CSRAM_WIDTH,
    parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    csram_stream_if.slave  s_if,
    csram_param_if.master  p_if,
    output logic           busy,
    output logic           done,
    output logic           error
);
    localparam int CORE_W = $clog2(NUM_CORES_NEW);
    localparam int ADDR_W = $clog2(NUM_NEURONS);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES_NEW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

    state_e                 state_q, state_d;
    logic [CORE_W-1:0]      core_q, core_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [CSRAM_WIDTH-1:0] row;
    logic                   row_full;
    logic                   accept;
    logic                   clr;
    logic                   advance;

    // Abort kills the handshake and the write strobe in the same cycle.
    assign s_if.in_ready      = (state_q == ST_ASSEMBLE) && !abort;
    assign accept             = s_if.in_valid && s_if.in_ready;
    assign p_if.param_wen     = (state_q == ST_WRITE) && !abort;
    assign p_if.param_core    = core_q;
    assign p_if.param_addr    = addr_q;
    assign p_if.param_data_in = row;
    assign busy = (state_q == ST_ASSEMBLE) || (state_q == ST_WRITE) || (state_q == ST_VERIFY);
    assign done = (state_q == ST_DONE) && !abort;
    assign clr  = (state_q == ST_IDLE) && start;

    row_packer #(
        .CSRAM_WIDTH (CSRAM_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .accept_i   (accept),
        .word_i     (s_if.in_data),
        .row_o      (row),
        .row_full_o (row_full)
    );

    // Next-state and core/row address sequencing; the final row keeps its address.
    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        addr_d  = addr_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ASSEMBLE;
                    core_d  = '0;
                    addr_d  = '0;
                end
            end
            ST_ASSEMBLE: begin
                if (row_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef CSRAM_RECONFIG_VERIFY_EN
                state_d = ST_VERIFY;
`else
                advance = 1'b1;
`endif
            end
`ifdef CSRAM_RECONFIG_VERIFY_EN
            ST_VERIFY: begin
                advance = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (advance) begin
            state_d = ST_ASSEMBLE;
            if (addr_q == LAST_ADDR) begin
                if (core_q == LAST_CORE) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d = '0;
                    core_d = core_q + CORE_W'(1);
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            core_d  = core_q;
            addr_d  = addr_q;
        end
    end

    // State and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            core_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            addr_q  <= addr_d;
        end
    end

`ifdef CSRAM_RECONFIG_VERIFY_EN
    logic error_q, error_d;

    // Sticky readback mismatch flag, cleared only by an accepted start.
    always_comb begin
        error_d = error_q;
        if (clr) begin
            error_d = 1'b0;
        end else if ((state_q == ST_VERIFY) && !abort && (p_if.param_data_out != row)) begin
            error_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) error_q <= 1'b0;
        else        error_q <= error_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_csram_reconfig_loader.sv
// Randomized self-checking bench for csram_reconfig_loader (2 cores x 4 rows,
// 40-bit rows from 16-bit words).
module tb_csram_reconfig_loader;

    localparam int NC     = 2;
    localparam int NN     = 4;
    localparam int CSW    = 40;
    localparam int WW     = 16;
    localparam int WPR    = 3;
    localparam int NROWS  = NC * NN;
    localparam int NWORDS = NROWS * WPR;
`ifdef CSRAM_RECONFIG_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error;

    csram_stream_if #(.WORD_WIDTH(WW)) s_if ();
    csram_param_if  #(.CORE_W(1), .ADDR_W(2), .CSRAM_WIDTH(CSW)) p_if ();

    csram_reconfig_loader #(
        .NUM_CORES_NEW (NC),
        .CSRAM_WIDTH   (CSW),
        .NUM_NEURONS   (NN),
        .WORD_WIDTH    (WW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .s_if  (s_if),
        .p_if  (p_if),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    // Per-core parameter memory with a one-cycle registered readback.
    logic [CSW-1:0] mem [NROWS];
    logic [CSW-1:0] rd_q;
    bit             corrupt_en = 1'b0;
    int             mem_idx;

    assign mem_idx = int'(p_if.param_core) * NN + int'(p_if.param_addr);

    always @(posedge clk) begin
        if (p_if.param_wen) mem[mem_idx] <= p_if.param_data_in;
        rd_q <= p_if.param_wen ? p_if.param_data_in : mem[mem_idx];
    end

    assign p_if.param_data_out = rd_q ^ ((corrupt_en && p_if.param_core == 1'b1 && p_if.param_addr == 2'd2)
                                         ? CSW'(1) : CSW'(0));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_load(input string name, input bit toggle, input bit fixed_first,
                            input int abort_rows, input int start_at, input bit corrupt);
        logic [WW-1:0]    words [NWORDS];
        logic [3*WW-1:0]  cat;
        logic [CSW-1:0]   exp_row;
        logic             hold_core;
        logic [1:0]       hold_addr;
        int cyc, hs, wen_n, done_n, last_hs, prev_wen, r, quiet_bad;
        bit aborted, start_sent, hold_chk;

        for (int i = 0; i < NWORDS; i++) words[i] = WW'($urandom);
        if (fixed_first) begin
            words[0] = 16'h1111;
            words[1] = 16'h2222;
            words[2] = 16'hABCD;
        end
        corrupt_en = corrupt;
        cyc = 0; hs = 0; wen_n = 0; done_n = 0; last_hs = -100; prev_wen = -100;
        aborted = 1'b0; start_sent = 1'b0; hold_chk = 1'b0;
        hold_core = 1'b0; hold_addr = 2'd0;

        @(negedge clk);
        start = 1'b1; abort = 1'b0; s_if.in_valid = 1'b0;

        while (cyc < 300 && !aborted && done_n == 0) begin
            @(negedge clk);
            start = (start_at >= 0) && !start_sent && (hs == start_at);
            s_if.in_valid = (hs < NWORDS) && (!toggle || (cyc % 2 == 1));
            s_if.in_data  = (hs < NWORDS) ? words[hs] : '0;
            abort = (abort_rows >= 0) && (wen_n == abort_rows) && (cyc >= prev_wen + 1 + V);
            #1;
            if (cyc == 0) check({name, "_err_clr"}, error, 0);
            if (hold_chk) begin
                check({name, "_busy_start_core"}, p_if.param_core, hold_core);
                check({name, "_busy_start_addr"}, p_if.param_addr, hold_addr);
                check({name, "_busy_start_busy"}, busy, 1);
                hold_chk = 1'b0;
            end
            if (start) begin
                start_sent = 1'b1;
                hold_chk   = 1'b1;
                hold_core  = p_if.param_core;
                hold_addr  = p_if.param_addr;
            end
            if (abort) begin
                check({name, "_abort_ready"}, s_if.in_ready, 0);
                aborted = 1'b1;
            end
            if (p_if.param_wen) begin
                r = wen_n;
                check({name, "_wen_ready"}, s_if.in_ready, 0);
                if (r < NROWS) begin
                    cat     = {words[3*r+2], words[3*r+1], words[3*r]};
                    exp_row = cat[CSW-1:0];
                    check({name, "_core"}, p_if.param_core, r / NN);
                    check({name, "_addr"}, p_if.param_addr, r % NN);
                    check({name, "_data"}, p_if.param_data_in, exp_row);
                    check({name, "_err_mid"}, error, (V == 1 && corrupt && r >= 7) ? 1 : 0);
                    if (fixed_first && r == 0) check({name, "_pack"}, p_if.param_data_in, 40'hCD22221111);
                end else begin
                    check({name, "_extra_wen"}, r, NROWS - 1);
                end
                if (!toggle && prev_wen >= 0) check({name, "_row_period"}, cyc - prev_wen, WPR + 1 + V);
                prev_wen = cyc;
                wen_n++;
            end
            if (s_if.in_valid && s_if.in_ready) begin
                hs++;
                last_hs = cyc;
            end
            if (done) begin
                done_n++;
                check({name, "_done_lat"}, cyc - last_hs, 2 + V);
                check({name, "_done_busy"}, busy, 0);
                check({name, "_done_err"}, error, (V == 1 && corrupt) ? 1 : 0);
            end
            cyc++;
        end

        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            #1;
            check({name, "_abort_busy"}, busy, 0);
            check({name, "_abort_core"}, p_if.param_core, abort_rows / NN);
            check({name, "_abort_addr"}, p_if.param_addr, abort_rows % NN);
            check({name, "_abort_wens"}, wen_n, abort_rows);
            check({name, "_abort_hs"}, hs, abort_rows * WPR);
        end else begin
            check({name, "_wen_count"}, wen_n, NROWS);
            check({name, "_done_count"}, done_n, 1);
        end

        // Idle afterwards: nothing accepted, written or completed.
        quiet_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_if.in_valid = 1'b1;
            #1;
            if (s_if.in_ready || p_if.param_wen || done || busy) quiet_bad++;
        end
        check({name, "_idle_quiet"}, quiet_bad, 0);
        s_if.in_valid = 1'b0;
    endtask

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_error", error, 0);
        check("rst_ready", s_if.in_ready, 0);
        check("rst_wen",   p_if.param_wen, 0);
        check("rst_core",  p_if.param_core, 0);
        check("rst_addr",  p_if.param_addr, 0);
        check("rst_data",  p_if.param_data_in, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_load("full",   1'b0, 1'b1, -1, -1, 1'b0);
        run_load("stall",  1'b1, 1'b0, -1,  4, 1'b0);
        run_load("abort",  1'b0, 1'b0,  4, -1, 1'b0);
        run_load("verify", 1'b0, 1'b0, -1, -1, 1'b1);
        run_load("reload", 1'b0, 1'b0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
